// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow. A
// start/busy/done handshake wraps the serial datapath.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   // cnt must reach WIDTH without wrapping, hence the extra bit.
   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] sa_q, sb_q, sd_q;
   logic [WIDTH-1:0] sd_d;
   logic             br_q, br_d, d_bit;
   logic [CW-1:0]    cnt_q;

   // Full-subtractor cell on the current LSBs, and accumulator shift-in at the MSB.
   always_comb begin
      d_bit = sa_q[0] ^ sb_q[0] ^ br_q;
      br_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
      sd_d  = sd_q >> 1;
      sd_d[WIDTH-1] = d_bit;
   end

   // Control FSM and serial datapath; all outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sd_q    <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         bout    <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  br_q    <= bin;
                  sd_q    <= '0;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               // start is deliberately ignored here
               sa_q  <= sa_q >> 1;
               sb_q  <= sb_q >> 1;
               br_q  <= br_d;
               sd_q  <= sd_d;
               cnt_q <= cnt_q + ONE;
               if (cnt_q == LAST) begin
                  diff    <= sd_d;
                  bout    <= br_d;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a WIDTH=8 and a WIDTH=1 instance, expected
// {bout,diff} pushed on start and popped by a done monitor.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0, bin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, bout8;
   logic [7:0] diff8;

   logic       start1 = 1'b0, bin1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       busy1, done1, bout1;
   logic [0:0] diff1;

   int n_chk = 0, n_err = 0;
   int spur8 = 0, spur1 = 0;
   logic prev8 = 1'b0, prev1 = 1'b0;
   logic [8:0] q8[$];
   logic [1:0] q1[$];

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
      .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (done8) begin
         chk("done8_pulse_width", 64'(prev8), 64'd0);
         if (q8.size() != 0) chk("res8", 64'({bout8, diff8}), 64'(q8.pop_front()));
         else spur8++;
      end
      if (done1) begin
         chk("done1_pulse_width", 64'(prev1), 64'd0);
         if (q1.size() != 0) chk("res1", 64'({bout1, diff1}), 64'(q1.pop_front()));
         else spur1++;
      end
      prev8 <= done8;
      prev1 <= done1;
   end

   // One WIDTH=8 operation: checks busy duration, done arrival and return to idle.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi);
      int nb = 0, cyc = 0;
      @(negedge clk);
      a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
      q8.push_back(9'({1'b0, a}) - 9'({1'b0, b}) - 9'(bi));
      @(negedge clk);
      start8 = 1'b0; a8 = $urandom; b8 = $urandom; bin8 = 1'($urandom);
      while (!done8 && cyc < 30) begin
         if (busy8) nb++;
         @(negedge clk);
         cyc++;
      end
      chk("busy8_cycles", 64'(nb), 64'd8);
      chk("done8_seen", 64'(done8), 64'd1);
      @(negedge clk);
      chk("idle8_after", 64'({busy8, done8}), 64'd0);
   endtask

   task automatic run1(input logic a, input logic b, input logic bi);
      int nb = 0, cyc = 0;
      @(negedge clk);
      a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
      q1.push_back(2'({1'b0, a}) - 2'({1'b0, b}) - 2'(bi));
      @(negedge clk);
      start1 = 1'b0;
      while (!done1 && cyc < 10) begin
         if (busy1) nb++;
         @(negedge clk);
         cyc++;
      end
      chk("busy1_cycles", 64'(nb), 64'd1);
      chk("done1_seen", 64'(done1), 64'd1);
   endtask

   initial begin
      int k;
      int dcount;
      // reset values
      repeat (2) @(negedge clk);
      chk("rst8_outs", 64'({busy8, done8, bout8, diff8}), 64'd0);
      chk("rst1_outs", 64'({busy1, done1, bout1, diff1}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle8_no_start", 64'({busy8, done8}), 64'd0);

      // directed cases
      run8(8'h5A, 8'h23, 1'b0);
      run8(8'h00, 8'h01, 1'b0);
      run8(8'h10, 8'h10, 1'b1);
      run8(8'h10, 8'h10, 1'b0);
      run8(8'hFF, 8'h00, 1'b1);
      run8(8'h00, 8'hFF, 1'b1);
      for (int i = 0; i < 6; i++) run8(8'($urandom), 8'($urandom), 1'($urandom));

      // start during RUN ignored, then back-to-back start from DONE
      @(negedge clk);
      a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
      q8.push_back(9'h07F);
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b1; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      k = 0;
      while (!done8 && k < 30) begin @(negedge clk); k++; end
      chk("first_done_seen", 64'(done8), 64'd1);
      a8 = 8'h03; b8 = 8'h05; bin8 = 1'b0; start8 = 1'b1;
      q8.push_back(9'h1FE);
      @(negedge clk);
      start8 = 1'b0;
      chk("b2b_busy", 64'(busy8), 64'd1);
      k = 1;
      while (!done8 && k < 30) begin @(negedge clk); k++; end
      chk("b2b_gap", 64'(k), 64'd9);

      // reset mid-RUN: asynchronous clear, no later done
      @(negedge clk);
      a8 = 8'hC3; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 64'(busy8), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_outs", 64'({busy8, done8, bout8, diff8}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done8 || busy8) dcount++;
      end
      chk("no_activity_after_rst", 64'(dcount), 64'd0);
      run8(8'h09, 8'h04, 1'b0);

      // WIDTH=1 exhaustive
      for (int i = 0; i < 8; i++) run1(i[2], i[1], i[0]);

      repeat (3) @(negedge clk);
      chk("q8_drained", 64'(q8.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      chk("spurious_done8", 64'(spur8), 64'd0);
      chk("spurious_done1", 64'(spur1), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
